fb_rd_line_sched: RTL and testbench
===================================

Name: fb_rd_line_sched

Overview:
- Per-frame, per-line read scheduler for the frame-buffer read path.
- Issues one DDR line-read request per active line, limited by the credit count of a downstream line buffer.
- Shadows the format configuration (DDR bytes/pixel, target BPC) so the reconcat read pipeline only sees changes at a frame boundary.
- Sits between the register block / timing generator and the DDR read master plus line FIFO that feed the reconcat datapath.

Parameters:
- C_ADDR_W, 32, DDR byte address width.
- C_H_W, 16, width of the pixel-count fields.
- C_V_W, 16, width of the line-count fields.
- C_BURST_BYTES, 64, request byte-length granule; must be a power of 2.
- C_LINE_BUF_NUM, 2, lines the downstream buffer holds; legal range 1..7.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; synchronous, active-high.
- CFG_BASE_ADDR, in, C_ADDR_W, frame base byte address.
- CFG_STRIDE, in, C_ADDR_W, line pitch in bytes.
- CFG_HACTIVE, in, C_H_W, pixels per line.
- CFG_VACTIVE, in, C_V_W, lines per frame.
- CFG_DDR_BYTE_NUM, in, 8, bytes per pixel in DDR; legal range 1..16.
- CFG_TARGET_BPC, in, 4, target bits per component.
- CFG_UPDATE, in, 1, one-cycle pulse meaning the CFG_* values are valid to take.
- VS_I, in, 1, vertical sync from the output timing; level signal.
- RD_REQ, out, 1, line read request.
- RD_ADDR, out, C_ADDR_W, line start byte address.
- RD_BYTES, out, C_H_W+8, line byte length.
- RD_ACK, in, 1, read master accepts the request.
- RD_DONE, in, 1, one-cycle pulse when the last beat of a line is written to the buffer.
- LINE_CONSUMED_I, in, 1, one-cycle pulse when the consumer has drained one buffered line.
- ACTUAL_DDR_BYTE_NUM_O, out, 8, shadowed DDR bytes/pixel.
- TARGET_BPC_O, out, 4, shadowed target BPC.
- FRAME_ACTIVE_O, out, 1, high from frame start until the last line is done.
- FRAME_ERR_O, out, 1, one-cycle pulse on VS during an active frame.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; pending-update flag 0.
- Config capture:
  - CFG_UPDATE copies CFG_* into a pending set and sets the pending flag.
  - On a VS_I rising edge (registered edge detect) with the pending flag set, the pending set moves to the active shadow one cycle later and the flag clears.
  - ACTUAL_DDR_BYTE_NUM_O and TARGET_BPC_O come from the active shadow.
  - CFG_UPDATE in the same cycle as the VS edge is captured into pending and takes effect at the next VS.
- Line byte length: RD_BYTES = ceil(HACTIVE*DDR_BYTE_NUM / C_BURST_BYTES)*C_BURST_BYTES.
  - Computed once per frame in the LOAD state and registered.
- Line address: RD_ADDR = BASE + line_idx*STRIDE, produced by an accumulator (add STRIDE per line), not a multiplier. Wraps modulo 2^C_ADDR_W.
- Credits: credit = C_LINE_BUF_NUM - (lines in flight + lines buffered).
  - Decrement on request handshake (RD_REQ && RD_ACK).
  - Increment on LINE_CONSUMED_I.
  - When both happen in the same cycle, credit is unchanged.
  - Credit never exceeds C_LINE_BUF_NUM; a LINE_CONSUMED_I at the maximum is ignored.
- FSM:
  - IDLE: on VS edge → LOAD.
  - LOAD (1 cycle): apply shadow; compute RD_BYTES; set RD_ADDR = BASE; line_idx=0; FRAME_ACTIVE_O=1; → REQ if VACTIVE≠0 and HACTIVE≠0, else → IDLE with FRAME_ACTIVE_O=0.
  - REQ: RD_REQ=1 when credit>0. RD_REQ, RD_ADDR and RD_BYTES stay stable until RD_ACK. On the handshake → WAIT.
  - WAIT: on RD_DONE, line_idx++ and RD_ADDR += STRIDE. If line_idx == VACTIVE → DRAIN, else → REQ.
  - DRAIN: wait until credit == C_LINE_BUF_NUM; FRAME_ACTIVE_O=0; → IDLE.
- Latency: VS edge registered at cycle N → LOAD at N+1 → RD_REQ may assert at N+2.
- VS edge in REQ, WAIT or DRAIN:
  - FRAME_ERR_O pulses.
  - In REQ with the request not yet acknowledged: drop RD_REQ and go to LOAD next cycle.
  - In WAIT: finish the outstanding line (await RD_DONE) first, then LOAD.
  - In DRAIN: go to LOAD directly. Credits are not reset in any case.
- RD_DONE outside WAIT is ignored. At most one line is ever in flight.

Decomposition:
- Package fb_rd_pkg holds:
  - FSM state enum {IDLE, LOAD, REQ, WAIT, DRAIN};
  - cfg struct (base, stride, hactive, vactive, byte_num, bpc);
  - function burst_round(bytes).
- One sub-module, fb_rd_credit_cnt: saturating up/down counter with init value C_LINE_BUF_NUM.

Test Plan:
- HACTIVE=1920, DDR_BYTE_NUM=3, VACTIVE=4, BASE=0x1000, STRIDE=0x1800, RD_ACK/RD_DONE immediate, consume after each DONE → RD_BYTES=5760; RD_ADDR sequence 0x1000, 0x2800, 0x4000, 0x5800; FRAME_ACTIVE_O falls after the 4th line.
- HACTIVE=100, DDR_BYTE_NUM=3 → RD_BYTES=320 (300 rounded up to 64).
- C_LINE_BUF_NUM=2, LINE_CONSUMED_I held low → exactly 2 requests issued, RD_REQ stays 0; one LINE_CONSUMED_I pulse → third request on the next cycle.
- CFG_UPDATE (byte_num 3→4, bpc 8→10) mid-frame → outputs hold 3/8 until the next VS edge, then read 4/10 one cycle after the edge; same-cycle CFG_UPDATE+VS → applied one frame later.
- VS edge while in WAIT → FRAME_ERR_O pulse; RD_REQ stays 0 until RD_DONE; then LOAD and RD_ADDR=BASE.
- rst asserted while in WAIT with credit=0 → all outputs 0, credit restored to C_LINE_BUF_NUM, FSM in IDLE; a later RD_DONE is ignored.

Source files
------------

// File: rtl/fb_rd_pkg.sv
// fb_rd_pkg: shared types, widths and helpers for the frame-buffer line read scheduler
package fb_rd_pkg;
  localparam int P_ADDR_W  = 32;
  localparam int P_H_W     = 16;
  localparam int P_V_W     = 16;
  localparam int P_BYTES_W = P_H_W + 8;
  localparam int P_CRED_W  = 3;
  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, DRAIN} state_t;
  typedef struct packed {
    logic [P_ADDR_W-1:0] base;
    logic [P_ADDR_W-1:0] stride;
    logic [P_H_W-1:0]    hactive;
    logic [P_V_W-1:0]    vactive;
    logic [7:0]          byte_num;
    logic [3:0]          bpc;
  } cfg_t;
  function automatic logic [P_BYTES_W-1:0] burst_round(input logic [P_BYTES_W-1:0] bytes, input int unsigned burst);
    logic [P_BYTES_W-1:0] m;
    m = P_BYTES_W'(burst - 1);
    return (bytes + m) & ~m;
  endfunction
endpackage

// File: rtl/fb_rd_credit_cnt.sv
// fb_rd_credit_cnt: saturating up/down line-buffer credit counter starting full
module fb_rd_credit_cnt
  import fb_rd_pkg::*;
#(
  parameter int C_MAX = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_dec,
  input  logic                i_inc,
  output logic [P_CRED_W-1:0] o_cnt,
  output logic                o_full
);
  localparam logic [P_CRED_W-1:0] L_MAX = P_CRED_W'(C_MAX);
  logic [P_CRED_W-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= L_MAX;
    else if (i_dec && !i_inc && r_cnt != '0)
      r_cnt <= r_cnt - P_CRED_W'(1);
    else if (i_inc && !i_dec && r_cnt != L_MAX)
      r_cnt <= r_cnt + P_CRED_W'(1);
  end
  assign o_cnt  = r_cnt;
  assign o_full = r_cnt == L_MAX;
endmodule

// File: rtl/fb_rd_line_sched.sv
// fb_rd_line_sched: per-frame line read scheduler with credit flow control and frame-boundary config shadowing
module fb_rd_line_sched
  import fb_rd_pkg::*;
#(
  parameter int C_ADDR_W       = P_ADDR_W,
  parameter int C_H_W          = P_H_W,
  parameter int C_V_W          = P_V_W,
  parameter int C_BURST_BYTES  = 64,
  parameter int C_LINE_BUF_NUM = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [C_ADDR_W-1:0] CFG_BASE_ADDR,
  input  logic [C_ADDR_W-1:0] CFG_STRIDE,
  input  logic [C_H_W-1:0]    CFG_HACTIVE,
  input  logic [C_V_W-1:0]    CFG_VACTIVE,
  input  logic [7:0]          CFG_DDR_BYTE_NUM,
  input  logic [3:0]          CFG_TARGET_BPC,
  input  logic                CFG_UPDATE,
  input  logic                VS_I,
  output logic                RD_REQ,
  output logic [C_ADDR_W-1:0] RD_ADDR,
  output logic [C_H_W+7:0]    RD_BYTES,
  input  logic                RD_ACK,
  input  logic                RD_DONE,
  input  logic                LINE_CONSUMED_I,
  output logic [7:0]          ACTUAL_DDR_BYTE_NUM_O,
  output logic [3:0]          TARGET_BPC_O,
  output logic                FRAME_ACTIVE_O,
  output logic                FRAME_ERR_O
);
  state_t              r_state, w_state_nxt;
  cfg_t                r_pend, r_act;
  logic                r_pend_vld, r_vs_d, r_vs_edge, r_restart;
  logic [C_V_W-1:0]    r_line_idx;
  logic [C_ADDR_W-1:0] r_addr;
  logic [C_H_W+7:0]    r_bytes;
  logic [P_CRED_W-1:0] w_credit;
  logic                w_cred_full, w_hs, w_idx_last;
  fb_rd_credit_cnt #(.C_MAX(C_LINE_BUF_NUM)) u_credit (
    .clk    (clk),
    .rst    (rst),
    .i_dec  (w_hs),
    .i_inc  (LINE_CONSUMED_I),
    .o_cnt  (w_credit),
    .o_full (w_cred_full)
  );
  // a VS edge while a request is pending withdraws it so the frame restarts cleanly
  assign RD_REQ                = r_state == REQ && w_credit != '0 && !r_vs_edge;
  assign w_hs                  = RD_REQ && RD_ACK;
  assign w_idx_last            = (r_line_idx + C_V_W'(1)) == r_act.vactive;
  assign RD_ADDR               = r_addr;
  assign RD_BYTES              = r_bytes;
  assign ACTUAL_DDR_BYTE_NUM_O = r_act.byte_num;
  assign TARGET_BPC_O          = r_act.bpc;
  assign FRAME_ACTIVE_O        = r_state != IDLE;
  assign FRAME_ERR_O           = r_vs_edge && (r_state == REQ || r_state == WAIT || r_state == DRAIN);
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = r_vs_edge ? LOAD : IDLE;
      LOAD:    w_state_nxt = (r_act.vactive != '0 && r_act.hactive != '0) ? REQ : IDLE;
      REQ:     w_state_nxt = r_vs_edge ? LOAD : w_hs ? WAIT : REQ;
      WAIT:    w_state_nxt = !RD_DONE ? WAIT : (r_restart || r_vs_edge) ? LOAD : w_idx_last ? DRAIN : REQ;
      DRAIN:   w_state_nxt = r_vs_edge ? LOAD : w_cred_full ? IDLE : DRAIN;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_act      <= '0;
      r_pend_vld <= 1'b0;
      r_vs_d     <= 1'b0;
      r_vs_edge  <= 1'b0;
      r_restart  <= 1'b0;
      r_line_idx <= '0;
      r_addr     <= '0;
      r_bytes    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_vs_d     <= VS_I;
      r_vs_edge  <= VS_I && !r_vs_d;
      r_pend_vld <= CFG_UPDATE || (r_pend_vld && !r_vs_edge);
      r_restart  <= r_state == WAIT && !RD_DONE && (r_restart || r_vs_edge);
      if (CFG_UPDATE)
        r_pend <= '{base: CFG_BASE_ADDR, stride: CFG_STRIDE, hactive: CFG_HACTIVE,
                    vactive: CFG_VACTIVE, byte_num: CFG_DDR_BYTE_NUM, bpc: CFG_TARGET_BPC};
      if (r_vs_edge && r_pend_vld)
        r_act <= r_pend;
      if (r_state == LOAD) begin
        r_addr     <= r_act.base;
        r_line_idx <= '0;
        r_bytes    <= burst_round(P_BYTES_W'(r_act.hactive) * P_BYTES_W'(r_act.byte_num), C_BURST_BYTES);
      end else if (r_state == WAIT && RD_DONE) begin
        r_line_idx <= r_line_idx + C_V_W'(1);
        r_addr     <= r_addr + r_act.stride;
      end
    end
  end
endmodule

// File: tb/tb_fb_rd_line_sched.sv
// tb_fb_rd_line_sched: scoreboard bench for the frame-buffer line read scheduler
module tb_fb_rd_line_sched;
  typedef struct packed {
    logic [31:0] addr;
    logic [23:0] bytes;
  } req_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_base = '0, cfg_stride = '0;
  logic [15:0] cfg_h = '0, cfg_v = '0;
  logic [7:0]  cfg_bn = '0;
  logic [3:0]  cfg_bpc = '0;
  logic        cfg_upd = 1'b0, vs = 1'b0;
  logic        rd_req, rd_ack, rd_done, cons;
  logic [31:0] rd_addr;
  logic [23:0] rd_bytes;
  logic [7:0]  act_bn;
  logic [3:0]  act_bpc;
  logic        fa, ferr;
  logic        ack_en = 1'b1, done_en = 1'b1, cons_en = 1'b1;
  logic        auto_done = 1'b0, auto_cons = 1'b0, man_done = 1'b0, man_cons = 1'b0;
  logic        hs_seen = 1'b0, done_seen = 1'b0;
  req_t        exp_q[$];
  req_t        mon_e;
  int          n_tests = 0, n_fail = 0, hs_cnt = 0, hs0 = 0;
  always #5 clk = ~clk;
  assign rd_ack  = rd_req & ack_en;
  assign rd_done = auto_done | man_done;
  assign cons    = auto_cons | man_cons;
  fb_rd_line_sched dut (
    .clk                   (clk),
    .rst                   (rst),
    .CFG_BASE_ADDR         (cfg_base),
    .CFG_STRIDE            (cfg_stride),
    .CFG_HACTIVE           (cfg_h),
    .CFG_VACTIVE           (cfg_v),
    .CFG_DDR_BYTE_NUM      (cfg_bn),
    .CFG_TARGET_BPC        (cfg_bpc),
    .CFG_UPDATE            (cfg_upd),
    .VS_I                  (vs),
    .RD_REQ                (rd_req),
    .RD_ADDR               (rd_addr),
    .RD_BYTES              (rd_bytes),
    .RD_ACK                (rd_ack),
    .RD_DONE               (rd_done),
    .LINE_CONSUMED_I       (cons),
    .ACTUAL_DDR_BYTE_NUM_O (act_bn),
    .TARGET_BPC_O          (act_bpc),
    .FRAME_ACTIVE_O        (fa),
    .FRAME_ERR_O           (ferr)
  );
  always @(negedge clk) begin
    hs_seen   = rd_req && rd_ack;
    done_seen = rd_done;
    if (!rst && hs_seen) begin
      hs_cnt++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL req_unexpected: got addr=%h bytes=%0d, expected no request", rd_addr, rd_bytes);
      end else begin
        mon_e = exp_q.pop_front();
        if (rd_addr !== mon_e.addr || rd_bytes !== mon_e.bytes) begin
          n_fail++;
          $display("FAIL req_%0d: got addr=%h bytes=%0d, expected addr=%h bytes=%0d",
                   hs_cnt, rd_addr, rd_bytes, mon_e.addr, mon_e.bytes);
        end
      end
    end
  end
  always @(posedge clk) begin
    #1;
    auto_done = done_en && hs_seen;
    auto_cons = cons_en && done_seen;
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic at_neg;
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] a, input logic [23:0] b);
    exp_q.push_back('{addr: a, bytes: b});
  endtask
  task automatic set_cfg(input logic [31:0] b, input logic [31:0] s, input logic [15:0] h,
                         input logic [15:0] v, input logic [7:0] bn, input logic [3:0] bpc);
    cfg_base = b; cfg_stride = s; cfg_h = h; cfg_v = v; cfg_bn = bn; cfg_bpc = bpc;
    cfg_upd = 1'b1;
    step();
    cfg_upd = 1'b0;
  endtask
  task automatic vs_pulse;
    vs = 1'b1;
    step();
    vs = 1'b0;
  endtask
  task automatic pulse_cons;
    man_cons = 1'b1;
    step();
    man_cons = 1'b0;
  endtask
  task automatic wait_frame_end(input string name, input int budget);
    for (int i = 0; i < budget && fa; i++) at_neg();
    chk(name, fa, 0);
    step();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    step(3);
    at_neg();
    chk("rst_req_addr_bytes", {rd_req, rd_addr, rd_bytes}, 0);
    chk("rst_cfg_flags", {act_bn, act_bpc, fa, ferr}, 0);
    step();
    rst = 1'b0;
    step(2);
    set_cfg(32'h1000, 32'h1800, 16'd1920, 16'd4, 8'd3, 4'd8);
    push(32'h1000, 24'd5760); push(32'h2800, 24'd5760); push(32'h4000, 24'd5760); push(32'h5800, 24'd5760);
    hs0 = hs_cnt;
    at_neg();
    chk("cfg_pending_not_shadowed", act_bn, 0);
    step();
    vs = 1'b1;
    step();
    at_neg();
    chk("no_err_on_idle_edge", ferr, 0);
    chk("shadow_old_on_edge_cycle", act_bn, 0);
    step();
    vs = 1'b0;
    at_neg();
    chk("shadow_bn_bpc_after_edge", {act_bn, act_bpc}, {8'd3, 4'd8});
    chk("frame_active_in_load", fa, 1);
    wait_frame_end("t1_frame_end", 200);
    chk("t1_req_count", hs_cnt - hs0, 4);
    ack_en = 1'b0;
    set_cfg(32'h2000, 32'h0, 16'd100, 16'd1, 8'd3, 4'd8);
    push(32'h2000, 24'd320);
    vs_pulse();
    step(2);
    at_neg();
    chk("req_held_without_ack", rd_req, 1);
    chk("req_addr_held", rd_addr, 32'h2000);
    step();
    at_neg();
    chk("req_still_held", rd_req, 1);
    chk("bytes_rounded_320", rd_bytes, 24'd320);
    step();
    ack_en = 1'b1;
    wait_frame_end("t2_frame_end", 50);
    set_cfg(32'h3000, 32'h0, 16'd100, 16'd0, 8'd3, 4'd8);
    hs0 = hs_cnt;
    vs_pulse();
    step(6);
    at_neg();
    chk("zero_lines_no_req", {hs_cnt - hs0, 31'd0, fa}, 0);
    step();
    cons_en = 1'b0;
    set_cfg(32'h10000, 32'h100, 16'd64, 16'd4, 8'd3, 4'd8);
    push(32'h10000, 24'd192); push(32'h10100, 24'd192); push(32'h10200, 24'd192); push(32'h10300, 24'd192);
    hs0 = hs_cnt;
    vs_pulse();
    step(20);
    at_neg();
    chk("credit_limits_to_2", hs_cnt - hs0, 2);
    chk("req_low_without_credit", rd_req, 0);
    step();
    set_cfg(32'h20000, 32'h40, 16'd100, 16'd1, 8'd4, 4'd10);
    at_neg();
    chk("midframe_cfg_held", {act_bn, act_bpc}, {8'd3, 4'd8});
    step();
    man_cons = 1'b1;
    at_neg();
    chk("no_req_before_consume", rd_req, 0);
    step();
    man_cons = 1'b0;
    at_neg();
    chk("third_req_next_cycle", rd_req, 1);
    step(5);
    pulse_cons();
    step(5);
    at_neg();
    chk("drain_waits_credit", {hs_cnt - hs0, 31'd0, fa}, {32'd4, 31'd0, 1'b1});
    step();
    pulse_cons();
    step(3);
    at_neg();
    chk("drain_waits_second_credit", fa, 1);
    step();
    pulse_cons();
    wait_frame_end("t3_frame_end", 20);
    cons_en = 1'b1;
    push(32'h20000, 24'd448);
    vs = 1'b1;
    at_neg();
    chk("cfg_old_before_edge", {act_bn, act_bpc}, {8'd3, 4'd8});
    step();
    vs = 1'b0;
    at_neg();
    chk("cfg_old_on_edge", {act_bn, act_bpc}, {8'd3, 4'd8});
    step();
    at_neg();
    chk("cfg_new_after_edge", {act_bn, act_bpc}, {8'd4, 4'd10});
    wait_frame_end("t4_frame_end", 50);
    push(32'h20000, 24'd448);
    vs = 1'b1;
    step();
    vs = 1'b0;
    cfg_base = 32'h30000; cfg_stride = 32'h80; cfg_h = 16'd64; cfg_v = 16'd1; cfg_bn = 8'd2; cfg_bpc = 4'd12;
    cfg_upd = 1'b1;
    step();
    cfg_upd = 1'b0;
    at_neg();
    chk("same_cycle_update_deferred", {act_bn, act_bpc}, {8'd4, 4'd10});
    wait_frame_end("t5_frame_end", 50);
    push(32'h30000, 24'd128);
    vs_pulse();
    step(2);
    at_neg();
    chk("deferred_update_applied", {act_bn, act_bpc}, {8'd2, 4'd12});
    wait_frame_end("t5b_frame_end", 50);
    done_en = 1'b0;
    cons_en = 1'b0;
    set_cfg(32'h40000, 32'h100, 16'd64, 16'd4, 8'd2, 4'd8);
    push(32'h40000, 24'd128);
    hs0 = hs_cnt;
    vs_pulse();
    step(6);
    at_neg();
    chk("one_req_then_wait", hs_cnt - hs0, 1);
    step();
    vs = 1'b1;
    step();
    vs = 1'b0;
    at_neg();
    chk("err_pulse_in_wait", ferr, 1);
    step();
    at_neg();
    chk("err_single_cycle", ferr, 0);
    step(2);
    at_neg();
    chk("no_req_until_done", {rd_req, 31'd0, fa}, 1);
    step();
    push(32'h40000, 24'd128);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    at_neg();
    chk("load_after_done_no_req", rd_req, 0);
    step();
    at_neg();
    chk("restart_req_addr_base", {rd_req, rd_addr}, {1'b1, 32'h40000});
    step(3);
    rst = 1'b1;
    step(2);
    at_neg();
    chk("rst_in_wait_req_addr_bytes", {rd_req, rd_addr, rd_bytes}, 0);
    chk("rst_in_wait_cfg_flags", {act_bn, act_bpc, fa, ferr}, 0);
    step();
    rst = 1'b0;
    step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    step(3);
    at_neg();
    chk("done_ignored_after_rst", {rd_req, 31'd0, fa}, 0);
    step();
    done_en = 1'b1;
    set_cfg(32'h50000, 32'h100, 16'd64, 16'd4, 8'd2, 4'd8);
    push(32'h50000, 24'd128); push(32'h50100, 24'd128);
    hs0 = hs_cnt;
    vs_pulse();
    step(20);
    at_neg();
    chk("credit_restored_by_rst", hs_cnt - hs0, 2);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
